// File: rtl/riscv_pkg.sv
// Shared types and constants for the memory-port arbiter and its watchdog.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } arb_state_e;

  localparam int TIMEOUT_DEFAULT    = 256;
  localparam int FAIR_LIMIT_DEFAULT = 3;

  // Returned to the fetch stage when a fetch is aborted, so the pipeline
  // executes a harmless addi x0,x0,0 instead of garbage.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [31:0] DATA_ABORT_VALUE = 32'h0000_0000;

  // Saturating increment used by the fairness counter.
  function automatic logic [1:0] sat_inc2(input logic [1:0] value, input logic [1:0] limit);
    return (value >= limit) ? limit : value + 2'd1;
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Counts cycles spent waiting on the shared memory port and flags the cycle
// on which the access has to be abandoned.
module mem_watchdog
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic busy,
  input  logic ack,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] wait_cnt_q;
  logic [CW-1:0] wait_cnt_d;

  // Restart on every grant, advance on each busy cycle that lacks an ack.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (clear) begin
      wait_cnt_d = '0;
    end else if (busy && !ack) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign expired = busy && !ack && (wait_cnt_q == LAST_WAIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the instruction-fetch and data-memory requesters onto a single
// shared memory port, with data priority bounded by a fairness limit and a
// watchdog that aborts accesses the memory never acknowledges.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int TIMEOUT    = TIMEOUT_DEFAULT,
  parameter int FAIR_LIMIT = FAIR_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ready,
  output logic [31:0] dm_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_pipe,
  output logic        err_timeout
);

  localparam logic [1:0] FAIR_MAX = 2'(FAIR_LIMIT);

  arb_state_e  state_q, state_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  fair_cnt_q, fair_cnt_d;
  logic        err_timeout_q, err_timeout_d;
  logic        grant;
  logic        expired;

  mem_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (grant),
    .busy   (mem_req),
    .ack    (mem_ack),
    .expired(expired)
  );

  // Grant decision in IDLE, completion/abort handling while an access is open.
  always_comb begin
    state_d       = state_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    fair_cnt_d    = fair_cnt_q;
    err_timeout_d = err_timeout_q;
    grant         = 1'b0;
    if_ready      = 1'b0;
    if_rdata      = 32'h0;
    dm_ready      = 1'b0;
    dm_rdata      = 32'h0;

    case (state_q)
      IDLE: begin
        if (dm_req && !((fair_cnt_q == FAIR_MAX) && if_req)) begin
          state_d     = DATA;
          grant       = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          fair_cnt_d  = if_req ? sat_inc2(fair_cnt_q, FAIR_MAX) : 2'd0;
        end else if (if_req) begin
          state_d     = FETCH;
          grant       = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = 32'h0;
          fair_cnt_d  = 2'd0;
        end
      end

      FETCH: begin
        if (mem_ack) begin
          if_ready = 1'b1;
          if_rdata = mem_rdata;
          state_d  = IDLE;
        end else if (expired) begin
          if_ready      = 1'b1;
          if_rdata      = NOP_INSTR;
          err_timeout_d = 1'b1;
          state_d       = IDLE;
        end
      end

      DATA: begin
        if (mem_ack) begin
          dm_ready = 1'b1;
          dm_rdata = mem_rdata;
          state_d  = IDLE;
        end else if (expired) begin
          dm_ready      = 1'b1;
          dm_rdata      = DATA_ABORT_VALUE;
          err_timeout_d = 1'b1;
          state_d       = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched transaction fields, fairness counter and sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 32'h0;
      mem_wdata_q   <= 32'h0;
      fair_cnt_q    <= 2'd0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      fair_cnt_q    <= fair_cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign mem_req     = (state_q != IDLE);
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign err_timeout = err_timeout_q;
  assign stall_pipe  = (if_req & ~if_ready) | (dm_req & ~dm_ready);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: requesters and a memory responder drive
// the DUT while a monitor checks every ready pulse against a queue of
// hand-computed expected transactions.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ready;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_pipe;
  logic        err_timeout;

  // Memory responder controls.
  logic        manual_mem;
  logic        man_ack;
  logic [31:0] man_rdata;
  logic        resp_ack;
  logic [31:0] resp_rdata;
  int          resp_delay;
  logic [31:0] resp_data;
  int          wait_n;

  typedef struct {
    bit          is_data;
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          chk_rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int vectors;
  int errors;
  int lat_a;
  int lat_b;

  assign mem_ack   = manual_mem ? man_ack   : resp_ack;
  assign mem_rdata = manual_mem ? man_rdata : resp_rdata;

  mem_port_arbiter #(
    .TIMEOUT   (256),
    .FAIR_LIMIT(3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_ready   (if_ready),
    .if_rdata   (if_rdata),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_ready   (dm_ready),
    .dm_rdata   (dm_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .stall_pipe (stall_pipe),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic push_exp(input bit is_data, input logic [31:0] addr, input bit we,
                          input logic [31:0] wdata, input logic [31:0] rdata, input bit chk_rdata);
    exp_t e;
    e.is_data   = is_data;
    e.addr      = addr;
    e.we        = we;
    e.wdata     = wdata;
    e.rdata     = rdata;
    e.chk_rdata = chk_rdata;
    exp_q.push_back(e);
  endtask

  // Responder: acks resp_delay cycles into each access (never if negative).
  initial begin
    resp_ack   = 1'b0;
    resp_rdata = 32'h0;
    wait_n     = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req && !reset && !manual_mem && !resp_ack) begin
        if (wait_n == resp_delay) begin
          resp_ack   = 1'b1;
          resp_rdata = resp_data;
        end else begin
          wait_n++;
        end
      end else begin
        resp_ack   = 1'b0;
        resp_rdata = 32'h0;
        wait_n     = 0;
      end
    end
  end

  // Monitor: every ready pulse must match the next expected transaction.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && (if_ready || dm_ready)) begin
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("[TB] FAIL unexpected_ready: if_ready=%0b dm_ready=%0b, none expected", if_ready, dm_ready);
        end else begin
          mon_e = exp_q.pop_front();
          check_output("ready_port_is_data", {31'b0, dm_ready}, {31'b0, mon_e.is_data});
          check_output("both_ready", {31'b0, if_ready & dm_ready}, 32'h0);
          check_output("mem_req_at_ready", {31'b0, mem_req}, 32'h1);
          check_output("mem_addr", mem_addr, mon_e.addr);
          check_output("mem_we", {31'b0, mem_we}, {31'b0, mon_e.we});
          if (mon_e.we) begin
            check_output("mem_wdata", mem_wdata, mon_e.wdata);
          end
          if (mon_e.chk_rdata) begin
            check_output("rdata", mon_e.is_data ? dm_rdata : if_rdata, mon_e.rdata);
          end
        end
      end
    end
  end

  task automatic apply_fetch(input logic [31:0] addr, input int budget, input bit scramble,
                             input bit solo, output int lat);
    bit done;
    done    = 1'b0;
    lat     = 0;
    if_req  = 1'b1;
    if_addr = addr;
    while (!done && lat < budget) begin
      @(negedge clk);
      lat++;
      if (if_ready) begin
        done = 1'b1;
        if (solo) check_output("fetch_stall_at_ready", {31'b0, stall_pipe}, 32'h0);
      end else begin
        check_output("fetch_stall_waiting", {31'b0, stall_pipe}, 32'h1);
        if (scramble && mem_req) if_addr = ~addr;
      end
    end
    if (!done) begin
      vectors++;
      errors++;
      $display("[TB] FAIL fetch_wait: no if_ready after %0d cycles, expected one", budget);
    end
    @(posedge clk);
    #1;
    if_req  = 1'b0;
    if_addr = 32'h0;
  endtask

  task automatic apply_data(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                            input int budget, input bit keep, input bit solo, output int lat);
    bit done;
    done     = 1'b0;
    lat      = 0;
    dm_req   = 1'b1;
    dm_we    = we;
    dm_addr  = addr;
    dm_wdata = wdata;
    while (!done && lat < budget) begin
      @(negedge clk);
      lat++;
      if (dm_ready) begin
        done = 1'b1;
        if (solo) check_output("data_stall_at_ready", {31'b0, stall_pipe}, 32'h0);
      end else begin
        check_output("data_stall_waiting", {31'b0, stall_pipe}, 32'h1);
      end
    end
    if (!done) begin
      vectors++;
      errors++;
      $display("[TB] FAIL data_wait: no dm_ready after %0d cycles, expected one", budget);
    end
    @(posedge clk);
    #1;
    if (!keep) begin
      dm_req   = 1'b0;
      dm_we    = 1'b0;
      dm_addr  = 32'h0;
      dm_wdata = 32'h0;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_output(name, exp_q.size(), 32'h0);
  endtask

  initial begin
    vectors    = 0;
    errors     = 0;
    reset      = 1'b1;
    if_req     = 1'b0;
    if_addr    = 32'h0;
    dm_req     = 1'b0;
    dm_we      = 1'b0;
    dm_addr    = 32'h0;
    dm_wdata   = 32'h0;
    manual_mem = 1'b0;
    man_ack    = 1'b0;
    man_rdata  = 32'h0;
    resp_delay = 0;
    resp_data  = 32'h0;

    // Reset values.
    repeat (3) @(negedge clk);
    check_output("rst_mem_req", {31'b0, mem_req}, 32'h0);
    check_output("rst_mem_we", {31'b0, mem_we}, 32'h0);
    check_output("rst_mem_addr", mem_addr, 32'h0);
    check_output("rst_mem_wdata", mem_wdata, 32'h0);
    check_output("rst_if_ready", {31'b0, if_ready}, 32'h0);
    check_output("rst_dm_ready", {31'b0, dm_ready}, 32'h0);
    check_output("rst_err_timeout", {31'b0, err_timeout}, 32'h0);
    check_output("rst_stall", {31'b0, stall_pipe}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single fetch, ack after two wait cycles, address scrambled mid-access.
    @(posedge clk);
    #1;
    resp_delay = 2;
    resp_data  = 32'hDEAD_BEEF;
    push_exp(1'b0, 32'h0000_0100, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b1);
    apply_fetch(32'h0000_0100, 20, 1'b1, 1'b1, lat_a);
    check_output("t1_latency", lat_a, 32'd4);
    @(negedge clk);
    check_output("t1_single_pulse", {31'b0, if_ready}, 32'h0);
    check_output("t1_idle_req", {31'b0, mem_req}, 32'h0);
    check_output("t1_idle_stall", {31'b0, stall_pipe}, 32'h0);
    drain("t1_drain");

    // Simultaneous store and fetch: data wins, then fetch.
    @(posedge clk);
    #1;
    resp_delay = 0;
    resp_data  = 32'hCAFE_0001;
    push_exp(1'b1, 32'h0000_0200, 1'b1, 32'h0000_0055, 32'h0, 1'b0);
    push_exp(1'b0, 32'h0000_0300, 1'b0, 32'h0, 32'hCAFE_0001, 1'b1);
    fork
      apply_data(1'b1, 32'h0000_0200, 32'h0000_0055, 20, 1'b0, 1'b0, lat_a);
      apply_fetch(32'h0000_0300, 20, 1'b0, 1'b0, lat_b);
    join
    check_output("t2_data_latency", lat_a, 32'd2);
    check_output("t2_fetch_latency", lat_b, 32'd4);
    drain("t2_drain");

    // Fairness: continuous loads against a waiting fetch.
    resp_delay = 1;
    resp_data  = 32'h1111_2222;
    push_exp(1'b1, 32'h0000_0400, 1'b0, 32'h0, 32'h1111_2222, 1'b1);
    push_exp(1'b1, 32'h0000_0404, 1'b0, 32'h0, 32'h1111_2222, 1'b1);
    push_exp(1'b1, 32'h0000_0408, 1'b0, 32'h0, 32'h1111_2222, 1'b1);
    push_exp(1'b0, 32'h0000_0500, 1'b0, 32'h0, 32'h1111_2222, 1'b1);
    push_exp(1'b1, 32'h0000_040C, 1'b0, 32'h0, 32'h1111_2222, 1'b1);
    push_exp(1'b1, 32'h0000_0410, 1'b0, 32'h0, 32'h1111_2222, 1'b1);
    push_exp(1'b1, 32'h0000_0414, 1'b0, 32'h0, 32'h1111_2222, 1'b1);
    push_exp(1'b0, 32'h0000_0504, 1'b0, 32'h0, 32'h1111_2222, 1'b1);
    push_exp(1'b1, 32'h0000_0418, 1'b0, 32'h0, 32'h1111_2222, 1'b1);
    fork
      begin
        int lat_d;
        for (int i = 0; i < 7; i++) begin
          apply_data(1'b0, 32'h0000_0400 + 32'(4 * i), 32'h0, 60, (i < 6), 1'b0, lat_d);
        end
      end
      begin
        int lat_f;
        apply_fetch(32'h0000_0500, 60, 1'b0, 1'b0, lat_f);
        apply_fetch(32'h0000_0504, 60, 1'b0, 1'b0, lat_f);
      end
    join
    drain("t3_drain");

    // Fetch and load that the memory never acknowledges.
    check_output("t4_err_before", {31'b0, err_timeout}, 32'h0);
    resp_delay = -1;
    push_exp(1'b0, 32'h0000_0600, 1'b0, 32'h0, 32'h0000_0013, 1'b1);
    apply_fetch(32'h0000_0600, 300, 1'b0, 1'b1, lat_a);
    check_output("t4_fetch_latency", lat_a, 32'd257);
    check_output("t4_err_set", {31'b0, err_timeout}, 32'h1);
    resp_data = 32'h7777_7777;
    push_exp(1'b1, 32'h0000_0700, 1'b0, 32'h0, 32'h0000_0000, 1'b1);
    apply_data(1'b0, 32'h0000_0700, 32'h0, 300, 1'b0, 1'b1, lat_a);
    check_output("t4_data_latency", lat_a, 32'd257);
    resp_delay = 0;
    resp_data  = 32'h0BAD_F00D;
    push_exp(1'b0, 32'h0000_0800, 1'b0, 32'h0, 32'h0BAD_F00D, 1'b1);
    apply_fetch(32'h0000_0800, 20, 1'b0, 1'b1, lat_a);
    check_output("t4_err_sticky", {31'b0, err_timeout}, 32'h1);
    drain("t4_drain");

    // Reset during a data wait with a coincident ack.
    manual_mem = 1'b1;
    man_ack    = 1'b0;
    @(posedge clk);
    #1;
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h0000_0900;
    @(negedge clk);
    check_output("t5_idle_req", {31'b0, mem_req}, 32'h0);
    @(negedge clk);
    check_output("t5_data_req", {31'b0, mem_req}, 32'h1);
    check_output("t5_data_addr", mem_addr, 32'h0000_0900);
    reset     = 1'b1;
    man_rdata = 32'hFFFF_0000;
    man_ack   = 1'b1;
    #1;
    check_output("t5_no_ready_async", {31'b0, dm_ready}, 32'h0);
    @(posedge clk);
    #1;
    check_output("t5_mem_req", {31'b0, mem_req}, 32'h0);
    check_output("t5_mem_we", {31'b0, mem_we}, 32'h0);
    check_output("t5_mem_addr", mem_addr, 32'h0);
    check_output("t5_mem_wdata", mem_wdata, 32'h0);
    check_output("t5_if_ready", {31'b0, if_ready}, 32'h0);
    check_output("t5_dm_ready", {31'b0, dm_ready}, 32'h0);
    check_output("t5_err_cleared", {31'b0, err_timeout}, 32'h0);
    man_ack = 1'b0;
    dm_req  = 1'b0;
    dm_addr = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_output("t5_idle_after", {31'b0, mem_req}, 32'h0);

    // Stray ack while idle is ignored.
    man_ack = 1'b1;
    @(negedge clk);
    check_output("t6_idle_if_ready", {31'b0, if_ready}, 32'h0);
    check_output("t6_idle_dm_ready", {31'b0, dm_ready}, 32'h0);
    check_output("t6_idle_req", {31'b0, mem_req}, 32'h0);
    man_ack    = 1'b0;
    manual_mem = 1'b0;
    @(negedge clk);
    check_output("final_queue_empty", exp_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: TIMEOUT, 256, cycles without mem_ack before abort; FAIR_LIMIT, 3, consecutive data grants allowed while fetch waits.
REQ-002 clk  input  1  clock; all state changes on its rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 if_req  input  1  fetch-stage read request, held until if_ready.
REQ-005 if_addr  input  32  fetch address.
REQ-006 if_ready  output  1  fetch complete, one-cycle pulse.
REQ-007 if_rdata  output  32  fetched instruction, valid when if_ready=1.
REQ-008 dm_req  input  1  MEM-stage load/store request, held until dm_ready.
REQ-009 dm_we  input  1  1 = store, 0 = load.
REQ-010 dm_addr  input  32  data address.
REQ-011 dm_wdata  input  32  store data.
REQ-012 dm_ready  output  1  data access complete, one-cycle pulse.
REQ-013 dm_rdata  output  32  load data, valid when dm_ready=1.
REQ-014 mem_req  output  1  shared memory port request.
REQ-015 mem_we  output  1  shared port write enable.
REQ-016 mem_addr  output  32  shared port address.
REQ-017 mem_wdata  output  32  shared port write data.
REQ-018 mem_rdata  input  32  shared port read data, valid with mem_ack.
REQ-019 mem_ack  input  1  shared port completion.
REQ-020 stall_pipe  output  1  freezes all pipeline registers while any request is pending.
REQ-021 err_timeout  output  1  sticky timeout flag.

Function
REQ-022 FSM states SHALL be IDLE, FETCH, DATA; reset state IDLE.
REQ-023 IDLE: dm_req=1 -> DATA unless fair_cnt=FAIR_LIMIT and if_req=1, then FETCH; else if_req=1 -> FETCH; else stay IDLE.
REQ-024 On grant, mem_addr/mem_we/mem_wdata SHALL latch the winner's inputs (mem_we=0 for fetch) and stay stable until completion; requester input changes mid-transaction are ignored.
REQ-025 mem_req SHALL be 1 exactly while state is FETCH or DATA.
REQ-026 In FETCH/DATA, mem_ack=1 SHALL combinationally assert the matching ready with rdata=mem_rdata, and the FSM returns to IDLE at that edge; minimum latency request-to-ready is 1 cycle.
REQ-027 Requesters drop req in the cycle after ready; a req still high in IDLE is a new request.
REQ-028 fair_cnt (2-bit) SHALL increment on a DATA grant while if_req=1, saturate at FAIR_LIMIT, and clear on any FETCH grant or a DATA grant with if_req=0.
REQ-029 wait_cnt SHALL clear on each grant and increment each FETCH/DATA cycle without mem_ack.
REQ-030 When wait_cnt reaches TIMEOUT-1 without mem_ack: assert matching ready with rdata=0x00000013 (fetch) or 0x00000000 (data), set err_timeout, return to IDLE.
REQ-031 mem_ack in IDLE SHALL be ignored.
REQ-032 stall_pipe = (if_req & ~if_ready) | (dm_req & ~dm_ready), combinational.
REQ-033 err_timeout SHALL remain 1 until reset.

Reset
REQ-034 Reset SHALL force IDLE, fair_cnt=0, wait_cnt=0, err_timeout=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ready=0, dm_ready=0.
REQ-035 Reset mid-transaction SHALL abort with no ready pulse; a mem_ack coincident with reset is discarded.

Structure
REQ-036 riscv_pkg SHALL hold the FSM state type, TIMEOUT/FAIR_LIMIT defaults and the NOP constant 0x00000013.
REQ-037 The wait counter and timeout compare SHALL be sub-module mem_watchdog; all else in mem_port_arbiter.

Verification
REQ-038 if_req=1, if_addr=0x100, mem_ack after 2 cycles with mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_we=0, if_ready pulses once with if_rdata=0xDEADBEEF, stall_pipe 1 until then.
REQ-039 if_req and dm_req (store 0x55 to 0x200) together, ack immediate -> DATA first (mem_we=1, mem_wdata=0x55), then FETCH.
REQ-040 dm_req held continuously with new accesses, if_req high -> after 3 data grants the 4th grant is FETCH; fair_cnt back to 0.
REQ-041 fetch granted, mem_ack never -> after 256 waiting cycles if_ready=1, if_rdata=0x00000013, err_timeout=1 and stays 1.
REQ-042 reset asserted in DATA wait with mem_ack same cycle -> no dm_ready, all outputs at reset values, IDLE next cycle.
